// File: rtl/comparator_pkg.sv
// Shared types and helpers for the digit-serial magnitude comparator.
// Covers the FSM states, the verdict encoding and the sign fix applied at load.
package comparator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    RES_EQ = 2'd0,
    RES_GT = 2'd1,
    RES_LT = 2'd2
  } result_t;

  // Flipping the sign bit maps two's complement onto offset binary, so an
  // unsigned compare then orders signed values correctly.
  function automatic logic fix_msb(input logic msb, input logic is_signed);
    return msb ^ is_signed;
  endfunction

endpackage

// File: rtl/comparator_serial_if.sv
// Request/response bundle for comparator_serial.
// The requester drives operands and start; the comparator returns status and the result.
interface comparator_serial_if #(parameter int WIDTH = 8);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             a_gt_b;
  logic             a_eq_b;
  logic             a_lt_b;

  modport master (
    output start, is_signed, a, b,
    input  busy, done, a_gt_b, a_eq_b, a_lt_b
  );

  modport slave (
    input  start, is_signed, a, b,
    output busy, done, a_gt_b, a_eq_b, a_lt_b
  );
endinterface

// File: rtl/comparator_digit.sv
// Combinational unsigned compare of one DIGIT-bit slice.
// Used once per cycle on the top digit of the operand shift registers.
module comparator_digit #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  output logic             gt,
  output logic             lt
);
  assign gt = (a > b);
  assign lt = (a < b);
endmodule

// File: rtl/comparator_serial.sv
// Digit-serial magnitude comparator, MSB first, DIGIT bits per clock.
// Supports signed/unsigned operands, optional early exit, and back-to-back starts.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | comparing the top digit of the shift registers
// DONE  | one-cycle result strobe; a new start is accepted here
module comparator_serial
  import comparator_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DIGIT      = 2,
  parameter int EARLY_EXIT = 1
) (
  input logic clk,
  input logic reset,
  comparator_serial_if.slave bus
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sh_a, sh_b;
  logic [CW-1:0]    cnt;
  result_t          verdict, dig_res, final_res;
  logic             dig_gt, dig_lt, dig_diff;
  logic             load, finish;
  logic             gt_q, eq_q, lt_q;

  comparator_digit #(.DIGIT(DIGIT)) u_digit (
    .a  (sh_a[WIDTH-1 -: DIGIT]),
    .b  (sh_b[WIDTH-1 -: DIGIT]),
    .gt (dig_gt),
    .lt (dig_lt)
  );

  assign dig_diff = dig_gt | dig_lt;

  // An earlier differing digit always outranks the current one.
  always_comb begin
    dig_res = RES_EQ;
    if (dig_gt)      dig_res = RES_GT;
    else if (dig_lt) dig_res = RES_LT;
    final_res = (verdict != RES_EQ) ? verdict : dig_res;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (((EARLY_EXIT != 0) && dig_diff) || (cnt == '0)) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (load) begin
      sh_a    <= {fix_msb(bus.a[WIDTH-1], bus.is_signed), bus.a[WIDTH-2:0]};
      sh_b    <= {fix_msb(bus.b[WIDTH-1], bus.is_signed), bus.b[WIDTH-2:0]};
      cnt     <= CW'(N - 1);
      verdict <= RES_EQ;
    end else if (state == RUN) begin
      sh_a    <= sh_a << DIGIT;
      sh_b    <= sh_b << DIGIT;
      verdict <= final_res;
      if (cnt != '0) cnt <= cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gt_q <= 1'b0;
      eq_q <= 1'b0;
      lt_q <= 1'b0;
    end else if (finish) begin
      gt_q <= (final_res == RES_GT);
      eq_q <= (final_res == RES_EQ);
      lt_q <= (final_res == RES_LT);
    end
  end

  assign bus.busy   = (state == RUN);
  assign bus.done   = (state == DONE);
  assign bus.a_gt_b = gt_q;
  assign bus.a_eq_b = eq_q;
  assign bus.a_lt_b = lt_q;

endmodule
